// File: rtl/lfsr_pkg.sv
// Shared LFSR helpers: single Fibonacci step function and maximal-length tap masks.
package lfsr_pkg;

  // Maximal-length feedback masks; bit i set puts state[i] into the XOR feedback.
  localparam logic [7:0]  TAPS_8  = 8'hB8;
  localparam logic [15:0] TAPS_16 = 16'hD008;
  localparam logic [23:0] TAPS_24 = 24'hE10000;
  localparam logic [31:0] TAPS_32 = 32'h8020_0003;
  localparam logic [63:0] TAPS_64 = 64'hD800_0000_0000_0000;

  // One shift: feedback parity enters at bit 0, bits above width are cleared.
  function automatic logic [63:0] lfsr_step(input logic [63:0] state,
                                            input logic [63:0] taps,
                                            input int          width);
    logic [63:0] mask;
    logic        fb;
    mask = (width >= 64) ? {64{1'b1}} : ((64'd1 << width) - 64'd1);
    fb   = ^(state & taps & mask);
    return ((state << 1) | {63'd0, fb}) & mask;
  endfunction

endpackage

// File: rtl/lfsr_leap_comb.sv
// Combinational leap-forward: applies STEPS Fibonacci LFSR shifts to state in one cycle.
module lfsr_leap_comb
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS  = TAPS_16,
  parameter int               STEPS = 1
) (
  input  logic [WIDTH-1:0] state,
  output logic [WIDTH-1:0] next
);

  logic [WIDTH-1:0] chain [STEPS+1];

  assign chain[0] = state;

  generate
    for (genvar gi = 0; gi < STEPS; gi++) begin : g_stage
      assign chain[gi+1] = WIDTH'(lfsr_step(64'(chain[gi]), 64'(TAPS), WIDTH));
    end
  endgenerate

  assign next = chain[STEPS];

endmodule

// File: rtl/lfsr_prng_stream.sv
// Fibonacci-LFSR PRNG with valid/ready output, runtime reseed, zero-seed and
// lock-up protection, and wrap detection against the last loaded seed.
module lfsr_prng_stream
  import lfsr_pkg::*;
#(
  parameter int               WIDTH        = 16,
  parameter logic [WIDTH-1:0] TAPS         = TAPS_16,
  parameter int               OUT_W        = 16,
  parameter int               STEPS        = 1,
  parameter logic [WIDTH-1:0] DEFAULT_SEED = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             seed_zero,
  output logic             wrap,
  output logic [31:0]      word_count
);

  logic [WIDTH-1:0] state_reg;
  logic [WIDTH-1:0] seed_reg;
  logic [OUT_W-1:0] out_data_reg;
  logic             out_valid_reg;
  logic             seed_zero_reg;
  logic             wrap_reg;
  logic [31:0]      word_count_reg;

  logic [WIDTH-1:0] leap_next;
  logic [WIDTH-1:0] next_state;
  logic [WIDTH-1:0] seed_eff;
  logic             seed_is_zero;
  logic             advance;
  logic             handshake;

  lfsr_leap_comb #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS),
    .STEPS (STEPS)
  ) u_leap (
    .state (state_reg),
    .next  (leap_next)
  );

  // An all-zero state would never leave zero, so it is replaced by the default seed.
  assign next_state   = (state_reg == '0) ? DEFAULT_SEED : leap_next;
  assign seed_is_zero = (seed_data == '0);
  assign seed_eff     = seed_is_zero ? DEFAULT_SEED : seed_data;
  assign handshake    = out_valid_reg & out_ready;
  assign advance      = enable & (~out_valid_reg | out_ready) & ~seed_load;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= DEFAULT_SEED;
      seed_reg       <= DEFAULT_SEED;
      out_data_reg   <= '0;
      out_valid_reg  <= 1'b0;
      seed_zero_reg  <= 1'b0;
      wrap_reg       <= 1'b0;
      word_count_reg <= '0;
    end else begin
      seed_zero_reg <= 1'b0;
      wrap_reg      <= 1'b0;
      if (handshake) begin
        word_count_reg <= word_count_reg + 32'd1;
      end
      // Reseed wins over advance and discards any word still on the output.
      if (seed_load) begin
        state_reg      <= seed_eff;
        seed_reg       <= seed_eff;
        out_valid_reg  <= 1'b0;
        word_count_reg <= '0;
        seed_zero_reg  <= seed_is_zero;
      end else if (advance) begin
        state_reg     <= next_state;
        out_data_reg  <= next_state[OUT_W-1:0];
        out_valid_reg <= 1'b1;
        wrap_reg      <= (next_state == seed_reg);
      end else if (handshake) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign out_valid  = out_valid_reg;
  assign out_data   = out_data_reg;
  assign seed_zero  = seed_zero_reg;
  assign wrap       = wrap_reg;
  assign word_count = word_count_reg;

endmodule

// File: tb/tb_lfsr_prng_stream.sv
// Self-checking bench: STEPS=1 and STEPS=4 instances against a stream model,
// plus directed literal checks for first words, backpressure, reseed, reset and period.
module tb_lfsr_prng_stream;

  localparam int          W    = 16;
  localparam logic [15:0] TAPS = 16'hD008;
  localparam logic [15:0] DEF  = 16'h0001;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        seed_load;
  logic [15:0] seed_data;
  logic        out_ready;

  logic        v1, sz1, w1, v4, sz4, w4;
  logic [15:0] d1, d4;
  logic [31:0] c1, c4;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  lfsr_prng_stream #(.WIDTH(16), .TAPS(16'hD008), .OUT_W(16), .STEPS(1), .DEFAULT_SEED(16'h0001)) dut1 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .seed_load(seed_load), .seed_data(seed_data),
    .out_valid(v1), .out_ready(out_ready), .out_data(d1), .seed_zero(sz1), .wrap(w1), .word_count(c1));

  lfsr_prng_stream #(.WIDTH(16), .TAPS(16'hD008), .OUT_W(16), .STEPS(4), .DEFAULT_SEED(16'h0001)) dut4 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .seed_load(seed_load), .seed_data(seed_data),
    .out_valid(v4), .out_ready(out_ready), .out_data(d4), .seed_zero(sz4), .wrap(w4), .word_count(c4));

  // Stream model, index 0 = STEPS 1, index 1 = STEPS 4.
  int unsigned m_state [2];
  int unsigned m_seed  [2];
  int unsigned m_data  [2];
  int unsigned m_count [2];
  bit          m_valid [2];
  bit          m_sz    [2];
  bit          m_wrap  [2];

  function automatic int unsigned mstep(input int unsigned s);
    int unsigned par;
    par = $countones(s & 32'(TAPS)) % 2;
    return ((s * 2) + par) % 65536;
  endfunction

  function automatic int unsigned mleap(input int unsigned s, input int n);
    int unsigned r = s;
    for (int k = 0; k < n; k++) r = mstep(r);
    return r;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_state[d] = DEF; m_seed[d] = DEF; m_data[d] = 0; m_count[d] = 0;
      m_valid[d] = 0;   m_sz[d] = 0;     m_wrap[d] = 0;
    end
  endtask

  always @(posedge clk) begin
    if (reset_n) begin
      for (int d = 0; d < 2; d++) begin
        bit          took;
        int unsigned nx;
        took     = m_valid[d] && out_ready;
        m_sz[d]  = 0;
        m_wrap[d] = 0;
        if (took) m_count[d] = m_count[d] + 1;
        if (seed_load) begin
          m_state[d] = (seed_data == 0) ? DEF : seed_data;
          m_seed[d]  = m_state[d];
          m_valid[d] = 0;
          m_count[d] = 0;
          m_sz[d]    = (seed_data == 0);
        end else if (enable && (!m_valid[d] || out_ready)) begin
          nx = (m_state[d] == 0) ? DEF : mleap(m_state[d], (d == 0) ? 1 : 4);
          m_state[d] = nx;
          m_data[d]  = nx;
          m_valid[d] = 1;
          m_wrap[d]  = (nx == m_seed[d]);
        end else if (took) begin
          m_valid[d] = 0;
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      if (mismatched <= 40)
        $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      check("s1_valid", 64'(v1), 64'(m_valid[0]));
      check("s1_data",  64'(d1), 64'(m_data[0]));
      check("s1_count", 64'(c1), 64'(m_count[0]));
      check("s1_szero", 64'(sz1), 64'(m_sz[0]));
      check("s1_wrap",  64'(w1), 64'(m_wrap[0]));
      check("s4_valid", 64'(v4), 64'(m_valid[1]));
      check("s4_data",  64'(d4), 64'(m_data[1]));
      check("s4_count", 64'(c4), 64'(m_count[1]));
      check("s4_szero", 64'(sz4), 64'(m_sz[1]));
      check("s4_wrap",  64'(w4), 64'(m_wrap[1]));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int wraps;
    int wrap_at;
    logic [15:0] wrap_data;

    reset_n = 1'b0; enable = 1'b0; seed_load = 1'b0; seed_data = '0; out_ready = 1'b0;
    model_reset();

    // Model pins: four single steps from 1 reach 0x0011; one leap of 4 matches.
    check("model_pin_step4", 64'(mleap(1, 4)), 64'h0011);
    check("model_pin_step1", 64'(mstep(16'h0008)), 64'h0011);

    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 64'(v1), 64'd0);
    check("rst_data",  64'(d1), 64'd0);
    check("rst_count", 64'(c1), 64'd0);
    check("rst_flags", 64'({sz1, w1}), 64'd0);
    reset_n = 1'b1;
    $display("[tb] reset released");

    // First words from seed 1.
    seed_load = 1'b1; seed_data = 16'h0001;
    tick();
    seed_load = 1'b0; enable = 1'b1; out_ready = 1'b1;
    tick(); check("first_w0", 64'(d1), 64'h0002); check("leap4_w0", 64'(d4), 64'h0011);
    check("first_v0", 64'(v1), 64'd1);
    tick(); check("first_w1", 64'(d1), 64'h0004);
    check("leap4_w1", 64'(d4), 64'(mleap(1, 8)));
    tick(); check("first_w2", 64'(d1), 64'h0008);
    tick(); check("first_w3", 64'(d1), 64'h0011);
    $display("[tb] first-word sequence checked");

    // Backpressure after the first word.
    seed_load = 1'b1; seed_data = 16'h0001; out_ready = 1'b0;
    tick();
    seed_load = 1'b0;
    tick(); check("bp_first", 64'(d1), 64'h0002);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold_valid", 64'(v1), 64'd1);
      check("bp_hold_data",  64'(d1), 64'h0002);
      check("bp_hold_count", 64'(c1), 64'd0);
    end
    out_ready = 1'b1;
    tick(); check("bp_release_data", 64'(d1), 64'h0004); check("bp_release_count", 64'(c1), 64'd1);
    tick(); check("bp_next_data", 64'(d1), 64'h0008); check("bp_next_count", 64'(c1), 64'd2);
    $display("[tb] backpressure checked");

    // Zero seed substitution.
    seed_load = 1'b1; seed_data = 16'h0000;
    tick();
    check("zs_pulse", 64'(sz1), 64'd1); check("zs_valid", 64'(v1), 64'd0); check("zs_count", 64'(c1), 64'd0);
    seed_load = 1'b0;
    tick();
    check("zs_pulse_end", 64'(sz1), 64'd0); check("zs_restart", 64'(d1), 64'h0002);
    check("zs_restart_v", 64'(v1), 64'd1);
    $display("[tb] zero-seed checked");

    // Randomized traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      enable    = ($urandom_range(0, 9) < 8);
      out_ready = ($urandom_range(0, 9) < 7);
      seed_load = ($urandom_range(0, 49) == 0);
      seed_data = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
      tick();
    end
    seed_load = 1'b0;
    $display("[tb] random traffic done");

    // Asynchronous reset with a word pending.
    enable = 1'b1; out_ready = 1'b0;
    tick();
    check("mid_pending", 64'(v1), 64'd1);
    reset_n = 1'b0;
    model_reset();
    #1;
    check("mid_valid", 64'(v1), 64'd0); check("mid_data", 64'(d1), 64'd0);
    check("mid_count", 64'(c1), 64'd0); check("mid_data4", 64'(d4), 64'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1; out_ready = 1'b1;
    tick(); check("mid_restart", 64'(d1), 64'h0002);
    $display("[tb] mid-stream reset checked");

    // Full period from 0xACE1.
    enable = 1'b0; seed_load = 1'b1; seed_data = 16'hACE1;
    tick();
    seed_load = 1'b0; enable = 1'b1; out_ready = 1'b1;
    wraps = 0; wrap_at = -1; wrap_data = '0;
    for (int k = 1; k <= 65537; k++) begin
      tick();
      if (w1) begin
        wraps++;
        wrap_at   = k;
        wrap_data = d1;
      end
    end
    check("period_wraps", 64'(wraps), 64'd1);
    check("period_at", 64'(wrap_at), 64'd65535);
    check("period_data", 64'(wrap_data), 64'hACE1);
    $display("[tb] period checked: wraps=%0d at advance %0d", wraps, wrap_at);

    enable = 1'b0;
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
